bus_sram_slave: RTL and testbench
=================================

// Module: bus_sram_slave
// PURPOSE
//  Word-addressed single-port SRAM target for the bus_if req/gnt/rvalid protocol.
//  Sits directly downstream of the 2-master/1-slave arbiter, on its slave port.
//  Serves instruction and data traffic with programmable wait states.
//  Returns exactly one response per granted request.
// PARAMETERS
//  MEM_BASE     32'h0000_0000  byte base address of the window (aligned to MEM_SIZE)
//  MEM_SIZE     32'h0000_8000  window size in bytes; power of two, >= 4
//  WAIT_STATES  0              cycles req must be held before gnt (0..15)
//  INIT_FILE    ""             $readmemh image loaded at elaboration; "" = no load
// PORTS
//  clk_i       in   1   clock, rising edge
//  rst_ni      in   1   reset, asynchronous, active-low
//  slv         bus_if.slave    bus target port; member signals below
//   .req       in   1   request valid; held with addr/we/be/wdata until gnt
//   .gnt       out  1   request accepted this cycle
//   .addr      in   32  byte address; bits [1:0] ignored
//   .we        in   1   1 = write, 0 = read
//   .be        in   4   byte enables for writes
//   .wdata     in   32  write data
//   .rdata     out  32  read data, valid with rvalid, else 0
//   .rvalid    out  1   response strobe, one per grant
//   .err       out  1   error response, valid with rvalid
// BEHAVIOUR
//  Reset: FSM=IDLE, wait counter=0, gnt=0, rvalid=0, rdata=0, err=0. RAM contents are not cleared.
//  FSM IDLE:
//   - req & WAIT_STATES==0 -> gnt=1 combinationally, same cycle; stay IDLE.
//   - req & WAIT_STATES>0  -> cnt=WAIT_STATES-1, go WAIT; gnt=0.
//  FSM WAIT:
//   - req & cnt!=0 -> cnt--.
//   - req & cnt==0 -> gnt=1, go IDLE.
//   - !req (protocol violation) -> go IDLE, no access, no response.
//  Access: RAM index = addr[$clog2(MEM_SIZE)-1:2], modulo window.
//   - Write: updates only bytes with be[i]=1, in the gnt cycle.
//   - Read: rdata is registered.
//  Response: rvalid=1 exactly one cycle after each gnt cycle, for reads and writes.
//   - Write response: rdata=0.
//  Throughput: with WAIT_STATES=0, one access per cycle.
//   - gnt may coincide with rvalid of the previous access.
//  Read-after-write to the same word on consecutive grants returns the new data.
//  Reset asserted mid-operation:
//   - Pending response is dropped (rvalid forced 0).
//   - An in-flight write either completed at its gnt edge or did not occur.
//  addr outside the window still decodes modulo MEM_SIZE, unless BUS_SRAM_ERR_EN is defined.
// CONFIGURATION
//  `BUS_SRAM_ERR_EN defined:
//   - A request is an error if (addr & ~(MEM_SIZE-1)) != MEM_BASE, or if we=1 with be==0.
//   - An error request is granted normally.
//   - RAM is not written; rvalid=1 with err=1, rdata=0.
//  `BUS_SRAM_ERR_EN undefined:
//   - err tied 0.
//   - No address check; the access aliases modulo MEM_SIZE.
// STRUCTURE
//  bus_pkg:
//   - ADDR_W=32, DATA_W=32, BE_W=4.
//   - typedef enum logic {S_IDLE, S_WAIT} sram_state_e.
//  Sub-module sram_1rw:
//   - Synchronous single-port RAM with byte-enable write and registered read.
//   - Parameters DEPTH, INIT_FILE.
//  Top level holds FSM, wait counter, response register and error decode.
// TESTING
//  1. WAIT_STATES=0: write 0xDEADBEEF @0x10 be=4'hF, then read @0x10.
//     -> gnt in the request cycle; rvalid next cycle; rdata=0xDEADBEEF.
//  2. Write 0x11223344 @0x20 be=4'hF, then 0xAABBCCDD be=4'b0101, then read.
//     -> rdata=0x11BB33DD.
//  3. WAIT_STATES=3: req held from cycle 0.
//     -> gnt only in cycle 3; rvalid in cycle 4; next req waits a further 3 cycles.
//  4. Back-to-back reads @0x0,0x4,0x8 with WAIT_STATES=0.
//     -> gnt 3 consecutive cycles; rvalid 3 consecutive cycles, data in order.
//  5. ERR_EN, MEM_SIZE=0x8000: read @0x0000_8004.
//     -> gnt, then rvalid=1, err=1, rdata=0.
//     Without ERR_EN: same read returns word @0x4.
//  6. rst_ni low in the cycle after a read gnt.
//     -> rvalid stays 0; after release, IDLE; a subsequent read is served normally.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths and the SRAM target state type.
package bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic {S_IDLE, S_WAIT} sram_state_e;

endpackage

// File: rtl/bus_if.sv
// bus_if: req/gnt/rvalid bus between a master and a single target.
interface bus_if;
   import bus_pkg::*;

   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rdata, rvalid, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rdata, rvalid, err
   );

endinterface

// File: rtl/sram_1rw.sv
// sram_1rw: synchronous single-port RAM, byte-enable write, registered read.
module sram_1rw
   import bus_pkg::*;
#(
   parameter int unsigned DEPTH     = 8192,
   parameter int unsigned IDX_W     = 13,
   parameter              INIT_FILE = ""
) (
   input  logic              clk_i,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [BE_W-1:0]   be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/bus_sram_slave.sv
// bus_sram_slave: word-addressed SRAM target for bus_if with programmable wait states.
// Define BUS_SRAM_ERR_EN to flag out-of-window requests and empty-be writes with err.
//
//   state  | meaning
//   S_IDLE | no request pending; grants at once when WAIT_STATES == 0
//   S_WAIT | request held, counting wait states down to the grant
module bus_sram_slave
   import bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] MEM_BASE    = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] MEM_SIZE    = 32'h0000_8000,
   parameter int unsigned       WAIT_STATES = 0,
   parameter                    INIT_FILE   = ""
) (
   input logic  clk_i,
   input logic  rst_ni,
   bus_if.slave slv
);

   localparam int unsigned DEPTH   = MEM_SIZE / 4;
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   sram_state_e       state;
   logic [3:0]        cnt;
   logic              gnt;
   logic              err_req;
   logic              rvalid_q;
   logic              rd_q;
   logic              err_q;
   logic [IDX_W-1:0]  idx;
   logic [ADDR_W-3:0] word;
   logic [DATA_W-1:0] ram_rdata;
   logic              unused_addr;

   assign word        = slv.addr[ADDR_W-1:2];
   assign idx         = (DEPTH > 1) ? word[IDX_W-1:0] : '0;
   assign unused_addr = ^{slv.addr[1:0], word};

`ifdef BUS_SRAM_ERR_EN
   assign err_req = ((slv.addr & ~(MEM_SIZE - 32'd1)) != MEM_BASE) ||
                    (slv.we && (slv.be == '0));
`else
   assign err_req = 1'b0;
`endif

   always_comb begin
      gnt = 1'b0;
      case (state)
         S_IDLE:  gnt = slv.req && (WAIT_STATES == 0);
         S_WAIT:  gnt = slv.req && (cnt == 4'd0);
         default: gnt = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         rvalid_q <= 1'b0;
         rd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= gnt;
         rd_q     <= gnt && !slv.we;
         err_q    <= gnt && err_req;
         case (state)
            S_IDLE: begin
               if (slv.req && (WAIT_STATES != 0)) begin
                  cnt   <= WS_LOAD;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A dropped req abandons the request without a response.
               if (!slv.req || (cnt == 4'd0)) state <= S_IDLE;
               else                           cnt   <= cnt - 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   sram_1rw #(
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk_i (clk_i),
      .en    (gnt && !err_req),
      .we    (slv.we),
      .idx   (idx),
      .be    (slv.be),
      .wdata (slv.wdata),
      .rdata (ram_rdata)
   );

   assign slv.gnt    = gnt;
   assign slv.rvalid = rvalid_q;
   assign slv.err    = rvalid_q && err_q;
   assign slv.rdata  = (rvalid_q && rd_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: directed and random checks of bus_sram_slave against a word-array model.
module tb_bus_sram_slave;

`ifdef BUS_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam logic [31:0] MEM_BS = 32'h0000_0000;
   localparam logic [31:0] MEM_SZ = 32'h0000_8000;
   localparam int unsigned DEPTH0 = 8192;
   localparam int          WS1    = 3;

   logic clk;
   logic rst_n;

   bus_if b0 ();
   bus_if b1 ();

   bus_sram_slave #(
      .MEM_BASE (MEM_BS), .MEM_SIZE (MEM_SZ), .WAIT_STATES (0), .INIT_FILE ("")
   ) dut0 (.clk_i (clk), .rst_ni (rst_n), .slv (b0));

   bus_sram_slave #(
      .MEM_BASE (32'h0), .MEM_SIZE (32'h100), .WAIT_STATES (WS1), .INIT_FILE ("")
   ) dut1 (.clk_i (clk), .rst_ni (rst_n), .slv (b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem_m [int unsigned];
   logic [3:0]  kn_m  [int unsigned];

   bit          exp_rv;
   bit          exp_err;
   bit          exp_known;
   logic [31:0] exp_rd;

   int          held;
   bit          r1, w1, eg, pg;
   logic [31:0] prd, nrd, last_wr, wd;
   logic [31:0] ra;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus cycle on dut0; checks this cycle, then predicts next cycle's response.
   task automatic step0(input string tag, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      int unsigned idx;
      logic [31:0] cur;
      logic [3:0]  kn;
      bit          e;
      @(posedge clk); #1;
      b0.req = r; b0.we = w; b0.addr = a; b0.be = b; b0.wdata = d;
      @(negedge clk);
      chk({tag, ".gnt"},    {31'b0, b0.gnt},    {31'b0, r});
      chk({tag, ".rvalid"}, {31'b0, b0.rvalid}, {31'b0, exp_rv});
      chk({tag, ".err"},    {31'b0, b0.err},    {31'b0, exp_err});
      if (exp_known) chk({tag, ".rdata"}, b0.rdata, exp_rd);
      exp_rv = r; exp_err = 1'b0; exp_rd = '0; exp_known = 1'b1;
      if (r) begin
         idx = (a >> 2) % DEPTH0;
         e = ERR_EN && (((a & ~(MEM_SZ - 32'd1)) != MEM_BS) || (w && (b == 4'h0)));
         exp_err = e;
         if (!e && w) begin
            cur = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            kn  = kn_m.exists(idx)  ? kn_m[idx]  : 4'h0;
            for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
            mem_m[idx] = cur;
            kn_m[idx]  = kn | b;
         end else if (!e) begin
            exp_known = kn_m.exists(idx) && (kn_m[idx] == 4'hF);
            exp_rd    = exp_known ? mem_m[idx] : 32'h0;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      b0.req = 0; b0.we = 0; b0.addr = 0; b0.be = 0; b0.wdata = 0;
      b1.req = 0; b1.we = 0; b1.addr = 0; b1.be = 0; b1.wdata = 0;
      exp_rv = 0; exp_err = 0; exp_rd = 0; exp_known = 1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.gnt0",    {31'b0, b0.gnt},    32'h0);
      chk("rst.rvalid0", {31'b0, b0.rvalid}, 32'h0);
      chk("rst.rdata0",  b0.rdata,           32'h0);
      chk("rst.err0",    {31'b0, b0.err},    32'h0);
      chk("rst.rvalid1", {31'b0, b1.rvalid}, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) step0("pre", 1, 1, MEM_BS + 32'(4 * i), 4'hF, $urandom);

      step0("t1w", 1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      step0("t1r", 1, 0, 32'h10, 4'h0, 32'h0);
      step0("t1i", 0, 0, 32'h0,  4'h0, 32'h0);
      chk("t1.lit", b0.rdata, 32'hDEAD_BEEF);

      step0("t2w1", 1, 1, 32'h20, 4'hF,    32'h1122_3344);
      step0("t2w2", 1, 1, 32'h20, 4'b0101, 32'hAABB_CCDD);
      step0("t2r",  1, 0, 32'h20, 4'h0,    32'h0);
      step0("t2i",  0, 0, 32'h0,  4'h0,    32'h0);
      chk("t2.lit", b0.rdata, 32'h11BB_33DD);

      step0("t4r0", 1, 0, 32'h0, 4'h0, 32'h0);
      step0("t4r1", 1, 0, 32'h4, 4'h0, 32'h0);
      step0("t4r2", 1, 0, 32'h8, 4'h0, 32'h0);
      step0("t4i",  0, 0, 32'h0, 4'h0, 32'h0);

      step0("t5r", 1, 0, 32'h0000_8004, 4'h0, 32'h0);
      step0("t5i", 0, 0, 32'h0,         4'h0, 32'h0);

      // Wait-state target: gnt after WS1 held cycles, abandoned requests restart the count.
      held = 0; pg = 0; prd = 0; last_wr = 0;
      for (int k = 0; k < 30; k++) begin
         r1 = (k < 10) || (k == 11) || (k == 12) || (k >= 14 && k <= 20) || (k >= 24 && k <= 27);
         w1 = (k < 24);
         wd = $urandom;
         @(posedge clk); #1;
         b1.req = r1; b1.we = w1; b1.addr = 32'h40; b1.be = 4'hF; b1.wdata = wd;
         @(negedge clk);
         eg = r1 && (held == WS1);
         chk($sformatf("t3.gnt%0d", k),    {31'b0, b1.gnt},    {31'b0, eg});
         chk($sformatf("t3.rvalid%0d", k), {31'b0, b1.rvalid}, {31'b0, pg});
         chk($sformatf("t3.rdata%0d", k),  b1.rdata,           prd);
         nrd = (eg && !w1) ? last_wr : 32'h0;
         if (eg && w1) last_wr = wd;
         pg   = eg;
         prd  = nrd;
         held = (r1 && !eg) ? held + 1 : 0;
      end
      @(posedge clk); #1 b1.req = 0;

      step0("t6r", 1, 0, 32'h10, 4'h0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b0; b0.req = 0;
      #1;
      chk("t6.rvalid", {31'b0, b0.rvalid}, 32'h0);
      chk("t6.rdata",  b0.rdata,           32'h0);
      chk("t6.gnt",    {31'b0, b0.gnt},    32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_rv = 0; exp_err = 0; exp_rd = 0; exp_known = 1;
      step0("t6i0", 0, 0, 32'h0,  4'h0, 32'h0);
      step0("t6r2", 1, 0, 32'h10, 4'h0, 32'h0);
      step0("t6i1", 0, 0, 32'h0,  4'h0, 32'h0);

      for (int n = 0; n < 300; n++) begin
         ra = MEM_BS | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) ra = ra | (32'($urandom_range(1, 7)) << 15);
         step0("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra,
               4'($urandom_range(0, 15)), $urandom);
      end
      step0("rndi", 0, 0, 32'h0, 4'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
